// File: rtl/vote_booth_arbiter.sv
// Round-robin arbiter that lends a single voting booth to eligible requesters for a fixed session.
// Optional REJECT_STATS_EN adds reject_cnt and last_reject_age outputs.
module vote_booth_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int AGE_W       = 8,
    parameter int MIN_AGE     = 18,
    parameter int VOTE_CYCLES = 3,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*AGE_W-1:0] age,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       reject,
    output logic                     busy,
    output logic                     vote_done,
    output logic [CNT_W-1:0]         vote_cnt
`ifdef REJECT_STATS_EN
    ,
    output logic [CNT_W-1:0]         reject_cnt,
    output logic [AGE_W-1:0]         last_reject_age
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SES_W = (VOTE_CYCLES > 1) ? $clog2(VOTE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        VOTE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [AGE_W-1:0]   age_lat_reg, age_lat_next;
    logic [SES_W-1:0]   ses_reg, ses_next;
    logic [NUM_REQ-1:0] gnt_next, reject_next;
    logic               busy_next, vote_done_next;
    logic [CNT_W-1:0]   vote_cnt_next;

    logic [AGE_W-1:0]   age_arr [NUM_REQ];
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_age_unpack
            assign age_arr[gi] = age[gi*AGE_W +: AGE_W];
        end
    endgenerate

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            rr_ptr_reg  <= '0;
            age_lat_reg <= '0;
            ses_reg     <= '0;
            gnt         <= '0;
            reject      <= '0;
            busy        <= 1'b0;
            vote_done   <= 1'b0;
            vote_cnt    <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            rr_ptr_reg  <= rr_ptr_next;
            age_lat_reg <= age_lat_next;
            ses_reg     <= ses_next;
            gnt         <= gnt_next;
            reject      <= reject_next;
            busy        <= busy_next;
            vote_done   <= vote_done_next;
            vote_cnt    <= vote_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        rr_ptr_next    = rr_ptr_reg;
        age_lat_next   = age_lat_reg;
        ses_next       = ses_reg;
        gnt_next       = '0;
        reject_next    = '0;
        vote_done_next = 1'b0;
        vote_cnt_next  = vote_cnt;

        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    idx_next     = pick_idx;
                    age_lat_next = age_arr[pick_idx];
                    state_next   = CHECK;
                end
            end
            CHECK: begin
                rr_ptr_next = (idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : idx_reg + 1'b1;
                if (age_lat_reg >= AGE_W'(MIN_AGE)) begin
                    gnt_next[idx_reg] = 1'b1;
                    ses_next          = SES_W'(VOTE_CYCLES - 1);
                    state_next        = VOTE;
                end else begin
                    reject_next[idx_reg] = 1'b1;
                    state_next           = IDLE;
                end
            end
            VOTE: begin
                // A withdrawn request ends the session without counting it.
                if (!req[idx_reg]) begin
                    state_next = RELEASE;
                end else if (ses_reg == '0) begin
                    vote_done_next = 1'b1;
                    vote_cnt_next  = (vote_cnt == {CNT_W{1'b1}}) ? vote_cnt : vote_cnt + 1'b1;
                    state_next     = RELEASE;
                end else begin
                    gnt_next[idx_reg] = 1'b1;
                    ses_next          = ses_reg - 1'b1;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

`ifdef REJECT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reject_cnt      <= '0;
            last_reject_age <= '0;
        end else if (reject_next != '0) begin
            if (reject_cnt != {CNT_W{1'b1}}) begin
                reject_cnt <= reject_cnt + 1'b1;
            end
            last_reject_age <= age_lat_reg;
        end
    end
`else
    // Without statistics the latched age feeds only the eligibility decision.
`endif

endmodule
